// File: rtl/q_pkg.sv
// q_pkg: shared types and constants for the packet bridge (command FSM states,
// default widths, word-ratio helpers, header field layout).
package q_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } cmd_state_t;

    localparam int Q_PKT_MST_W = 128;
    localparam int Q_PKT_SLV_W = 64;

    // Header word carries the packet length in beats in its low byte.
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 8;

    function automatic int q_ratio(input int mst_w, input int slv_w);
        return mst_w / slv_w;
    endfunction

    // Index width for a counter over n slots; never narrower than one bit.
    function automatic int q_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/q_rsp_fifo.sv
// q_rsp_fifo: synchronous FIFO of DEPTH wide beats with full/empty flags and a
// combinational head read. Pushes while full are ignored.
module q_rsp_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/q_pkt_bridge.sv
// q_pkt_bridge: packs narrow slave writes into framed wide master command packets and
// buffers master response beats for narrow slave reads. Option: Q_PKT_BRIDGE_STATS_EN.
module q_pkt_bridge
    import q_pkg::*;
#(
    parameter int MST_W     = Q_PKT_MST_W,
    parameter int SLV_W     = Q_PKT_SLV_W,
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_slv_cmd_vld,
    input  logic             i_slv_cmd_rnw,
    input  logic [SLV_W-1:0] i_slv_cmd_dat,
    output logic             o_slv_rsp_vld,
    output logic [SLV_W-1:0] o_slv_rsp_dat,
    output logic             o_mst_cmd_vld,
    output logic             o_mst_cmd_sop,
    output logic             o_mst_cmd_eop,
    output logic [MST_W-1:0] o_mst_cmd_dat,
    input  logic             i_mst_rsp_vld,
    input  logic             i_mst_rsp_sop,
    input  logic             i_mst_rsp_eop,
    input  logic [MST_W-1:0] i_mst_rsp_dat,
`ifdef Q_PKT_BRIDGE_STATS_EN
    output logic [15:0]      o_stat_drop_cnt,
`endif
    output logic             o_dbg_cmd_state
);

    // No path has backpressure: any strobe (slave cmd, master cmd, master rsp)
    // is consumed in the very cycle it is high, and response strobes follow one cycle later.

    localparam int                RATIO     = q_ratio(MST_W, SLV_W);
    localparam int                WIDX_W    = q_idx_w(RATIO);
    localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(RATIO - 1);
    localparam logic [7:0]        MAX_N     = 8'(MAX_BEATS);

    cmd_state_t           state, state_nxt;
    logic [7:0]           n_beats, n_nxt;
    logic [7:0]           beat_idx, beat_nxt;
    logic [WIDX_W-1:0]    word_idx, word_nxt;
    logic [WIDX_W-1:0]    rd_idx;
    logic [MST_W-1:0]     pack, beat_data;
    logic [HDR_LEN_W-1:0] hdr_len;
    logic                 cmd_wr, cmd_rd, beat_done;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [MST_W-1:0] fifo_head;
    logic             rsp_drop, drop_mode;
    logic             rsp_eop_unused;

    assign cmd_wr          = i_slv_cmd_vld && !i_slv_cmd_rnw;
    assign cmd_rd          = i_slv_cmd_vld &&  i_slv_cmd_rnw;
    assign hdr_len         = i_slv_cmd_dat[HDR_LEN_LSB +: HDR_LEN_W];
    assign o_dbg_cmd_state = (state == DATA);
    // Response framing is carried by sop alone; eop needs no action here.
    assign rsp_eop_unused  = i_mst_rsp_eop;

    always_comb begin
        state_nxt = state;
        n_nxt     = n_beats;
        beat_nxt  = beat_idx;
        word_nxt  = word_idx;
        beat_done = 1'b0;
        beat_data = pack;
        beat_data[word_idx*SLV_W +: SLV_W] = i_slv_cmd_dat;
        case (state)
            IDLE: begin
                if (cmd_wr && hdr_len != '0 && hdr_len <= MAX_N) begin
                    state_nxt = DATA;
                    n_nxt     = hdr_len;
                    beat_nxt  = '0;
                    word_nxt  = '0;
                end
            end
            DATA: begin
                if (cmd_wr) begin
                    if (word_idx == WORD_LAST) begin
                        beat_done = 1'b1;
                        word_nxt  = '0;
                        if (beat_idx == n_beats - 8'd1) begin
                            state_nxt = IDLE;
                            beat_nxt  = '0;
                        end else begin
                            beat_nxt = beat_idx + 8'd1;
                        end
                    end else begin
                        word_nxt = word_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            n_beats  <= '0;
            beat_idx <= '0;
            word_idx <= '0;
            pack     <= '0;
        end else begin
            state    <= state_nxt;
            n_beats  <= n_nxt;
            beat_idx <= beat_nxt;
            word_idx <= word_nxt;
            if (state == DATA && cmd_wr) pack <= beat_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_mst_cmd_vld <= 1'b0;
            o_mst_cmd_sop <= 1'b0;
            o_mst_cmd_eop <= 1'b0;
            o_mst_cmd_dat <= '0;
        end else begin
            o_mst_cmd_vld <= beat_done;
            o_mst_cmd_sop <= beat_done && (beat_idx == 8'd0);
            o_mst_cmd_eop <= beat_done && (beat_idx == n_beats - 8'd1);
            o_mst_cmd_dat <= beat_done ? beat_data : '0;
        end
    end

    // Full is the registered flag, so a beat arriving while full drops even if
    // a pop happens in the same cycle.
    assign fifo_push = i_mst_rsp_vld && (!drop_mode || i_mst_rsp_sop) && !fifo_full;
    assign rsp_drop  = i_mst_rsp_vld && !fifo_push;
    assign fifo_pop  = cmd_rd && !fifo_empty && (rd_idx == WORD_LAST);

    q_rsp_fifo #(
        .W     (MST_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .arst_n(arst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (i_mst_rsp_dat),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            drop_mode     <= 1'b0;
            rd_idx        <= '0;
            o_slv_rsp_vld <= 1'b0;
            o_slv_rsp_dat <= '0;
        end else begin
            if (i_mst_rsp_vld) drop_mode <= rsp_drop;
            o_slv_rsp_vld <= cmd_rd;
            o_slv_rsp_dat <= (cmd_rd && !fifo_empty) ? fifo_head[rd_idx*SLV_W +: SLV_W] : '0;
            if (cmd_rd && !fifo_empty) begin
                rd_idx <= (rd_idx == WORD_LAST) ? '0 : rd_idx + 1'b1;
            end
        end
    end

`ifdef Q_PKT_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_stat_drop_cnt <= '0;
        end else if (rsp_drop && o_stat_drop_cnt != 16'hFFFF) begin
            o_stat_drop_cnt <= o_stat_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_q_pkt_bridge.sv
// tb_q_pkt_bridge: table vectors, hand sequences for drop/reset corners and a
// randomized run against a queue-based reference model of q_pkt_bridge.
module tb_q_pkt_bridge;

    localparam int MST_W     = 128;
    localparam int SLV_W     = 64;
    localparam int DEPTH     = 8;
    localparam int MAX_BEATS = 4;
    localparam int RATIO     = MST_W / SLV_W;

    typedef struct packed {
        logic             cvld;
        logic             crnw;
        logic [SLV_W-1:0] cdat;
        logic             mvld;
        logic             msop;
        logic             meop;
        logic [MST_W-1:0] mdat;
    } in_t;

    typedef struct packed {
        logic             svld;
        logic [SLV_W-1:0] sdat;
        logic             cvld;
        logic             csop;
        logic             ceop;
        logic [MST_W-1:0] cdat;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             arst_n;
    logic             i_slv_cmd_vld, i_slv_cmd_rnw;
    logic [SLV_W-1:0] i_slv_cmd_dat;
    logic             o_slv_rsp_vld;
    logic [SLV_W-1:0] o_slv_rsp_dat;
    logic             o_mst_cmd_vld, o_mst_cmd_sop, o_mst_cmd_eop;
    logic [MST_W-1:0] o_mst_cmd_dat;
    logic             i_mst_rsp_vld, i_mst_rsp_sop, i_mst_rsp_eop;
    logic [MST_W-1:0] i_mst_rsp_dat;
    logic             o_dbg_cmd_state;
`ifdef Q_PKT_BRIDGE_STATS_EN
    logic [15:0]      o_stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    q_pkt_bridge #(
        .MST_W(MST_W), .SLV_W(SLV_W), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .i_slv_cmd_vld(i_slv_cmd_vld), .i_slv_cmd_rnw(i_slv_cmd_rnw), .i_slv_cmd_dat(i_slv_cmd_dat),
        .o_slv_rsp_vld(o_slv_rsp_vld), .o_slv_rsp_dat(o_slv_rsp_dat),
        .o_mst_cmd_vld(o_mst_cmd_vld), .o_mst_cmd_sop(o_mst_cmd_sop), .o_mst_cmd_eop(o_mst_cmd_eop),
        .o_mst_cmd_dat(o_mst_cmd_dat),
        .i_mst_rsp_vld(i_mst_rsp_vld), .i_mst_rsp_sop(i_mst_rsp_sop), .i_mst_rsp_eop(i_mst_rsp_eop),
        .i_mst_rsp_dat(i_mst_rsp_dat),
`ifdef Q_PKT_BRIDGE_STATS_EN
        .o_stat_drop_cnt(o_stat_drop_cnt),
`endif
        .o_dbg_cmd_state(o_dbg_cmd_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    function automatic void cmp(string name, logic [MST_W-1:0] got, logic [MST_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit               m_in_pkt;
    int               m_len, m_sent, m_rdw, m_dcnt;
    bit               m_drop;
    logic [SLV_W-1:0] m_words[$];
    logic [MST_W-1:0] exp_q[$];

    function automatic void model_reset();
        m_in_pkt = 0; m_len = 0; m_sent = 0; m_rdw = 0; m_dcnt = 0; m_drop = 0;
        m_words.delete();
        exp_q.delete();
    endfunction

    function automatic out_t model_step(in_t v);
        out_t             e;
        bit               was_full;
        logic [MST_W-1:0] h;
        int               n;
        e = '0;
        was_full = (exp_q.size() == DEPTH);
        if (v.cvld && v.crnw) begin
            e.svld = 1'b1;
            if (exp_q.size() > 0) begin
                h = exp_q[0] >> (m_rdw * SLV_W);
                e.sdat = h[SLV_W-1:0];
                m_rdw++;
                if (m_rdw == RATIO) begin
                    m_rdw = 0;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (v.cvld && !v.crnw) begin
            if (!m_in_pkt) begin
                n = int'(v.cdat[7:0]);
                if (n >= 1 && n <= MAX_BEATS) begin
                    m_in_pkt = 1; m_len = n; m_sent = 0;
                    m_words.delete();
                end
            end else begin
                m_words.push_back(v.cdat);
                if (m_words.size() == RATIO) begin
                    e.cvld = 1'b1;
                    e.csop = (m_sent == 0);
                    e.ceop = (m_sent == m_len - 1);
                    for (int k = RATIO - 1; k >= 0; k--) e.cdat = (e.cdat << SLV_W) | MST_W'(m_words[k]);
                    m_words.delete();
                    m_sent++;
                    if (m_sent == m_len) m_in_pkt = 0;
                end
            end
        end
        if (v.mvld) begin
            if (was_full || (m_drop && !v.msop)) begin
                m_drop = 1;
                if (m_dcnt < 65535) m_dcnt++;
            end else begin
                m_drop = 0;
                exp_q.push_back(v.mdat);
            end
        end
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic in_t i_idle();
        return '0;
    endfunction
    function automatic in_t i_wr(logic [SLV_W-1:0] d);
        in_t v = '0;
        v.cvld = 1'b1; v.cdat = d;
        return v;
    endfunction
    function automatic in_t i_rd();
        in_t v = '0;
        v.cvld = 1'b1; v.crnw = 1'b1;
        return v;
    endfunction
    function automatic in_t i_rsp(logic s, logic e, logic [MST_W-1:0] d);
        in_t v = '0;
        v.mvld = 1'b1; v.msop = s; v.meop = e; v.mdat = d;
        return v;
    endfunction
    function automatic out_t o_none();
        return '0;
    endfunction
    function automatic out_t o_cmd(logic s, logic e, logic [MST_W-1:0] d);
        out_t o = '0;
        o.cvld = 1'b1; o.csop = s; o.ceop = e; o.cdat = d;
        return o;
    endfunction
    function automatic out_t o_rsp(logic [SLV_W-1:0] d);
        out_t o = '0;
        o.svld = 1'b1; o.sdat = d;
        return o;
    endfunction
    function automatic vec_t mkv(in_t i, out_t o);
        vec_t t;
        t.i = i; t.o = o;
        return t;
    endfunction
    function automatic logic [MST_W-1:0] beat(int k);
        return {SLV_W'(k + 100), SLV_W'(k)};
    endfunction

    task automatic cmp_out(string tag, out_t got, out_t exp);
        cmp({tag, "_slv_vld"}, MST_W'(got.svld), MST_W'(exp.svld));
        cmp({tag, "_slv_dat"}, MST_W'(got.sdat), MST_W'(exp.sdat));
        cmp({tag, "_cmd_vld"}, MST_W'(got.cvld), MST_W'(exp.cvld));
        cmp({tag, "_cmd_sop"}, MST_W'(got.csop), MST_W'(exp.csop));
        cmp({tag, "_cmd_eop"}, MST_W'(got.ceop), MST_W'(exp.ceop));
        cmp({tag, "_cmd_dat"}, got.cdat, exp.cdat);
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge and check it.
    task automatic step(input in_t v, output out_t got);
        out_t e;
        i_slv_cmd_vld = v.cvld; i_slv_cmd_rnw = v.crnw; i_slv_cmd_dat = v.cdat;
        i_mst_rsp_vld = v.mvld; i_mst_rsp_sop = v.msop; i_mst_rsp_eop = v.meop;
        i_mst_rsp_dat = v.mdat;
        e = model_step(v);
        @(posedge clk);
        #1;
        got.svld = o_slv_rsp_vld; got.sdat = o_slv_rsp_dat;
        got.cvld = o_mst_cmd_vld; got.csop = o_mst_cmd_sop; got.ceop = o_mst_cmd_eop;
        got.cdat = o_mst_cmd_dat;
        cmp_out("model", got, e);
        cmp("model_state", MST_W'(o_dbg_cmd_state), MST_W'(m_in_pkt));
`ifdef Q_PKT_BRIDGE_STATS_EN
        cmp("model_drop_cnt", MST_W'(o_stat_drop_cnt), MST_W'(m_dcnt));
`endif
        i_slv_cmd_vld = 1'b0; i_mst_rsp_vld = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(string tag);
        i_slv_cmd_vld = 1'b0; i_slv_cmd_rnw = 1'b0; i_slv_cmd_dat = '0;
        i_mst_rsp_vld = 1'b0; i_mst_rsp_sop = 1'b0; i_mst_rsp_eop = 1'b0; i_mst_rsp_dat = '0;
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        cmp({tag, "_slv_vld"}, MST_W'(o_slv_rsp_vld), '0);
        cmp({tag, "_slv_dat"}, MST_W'(o_slv_rsp_dat), '0);
        cmp({tag, "_cmd_vld"}, MST_W'(o_mst_cmd_vld), '0);
        cmp({tag, "_cmd_sop"}, MST_W'(o_mst_cmd_sop), '0);
        cmp({tag, "_cmd_eop"}, MST_W'(o_mst_cmd_eop), '0);
        cmp({tag, "_cmd_dat"}, o_mst_cmd_dat, '0);
        cmp({tag, "_state"}, MST_W'(o_dbg_cmd_state), '0);
`ifdef Q_PKT_BRIDGE_STATS_EN
        cmp({tag, "_drop_cnt"}, MST_W'(o_stat_drop_cnt), '0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[$];
    out_t got;
    in_t  v;
    int   drain[$];

    initial begin
        arst_n = 1'b1;
        do_reset("reset");

        // Packing, framing, header filtering, response word order, reads during DATA.
        tbl.push_back(mkv(i_wr(64'h1),   o_none()));
        tbl.push_back(mkv(i_wr(64'hA),   o_none()));
        tbl.push_back(mkv(i_wr(64'hB),   o_cmd(1, 1, {64'hB, 64'hA})));
        tbl.push_back(mkv(i_idle(),      o_none()));
        tbl.push_back(mkv(i_wr(64'h3),   o_none()));
        tbl.push_back(mkv(i_wr(64'h11),  o_none()));
        tbl.push_back(mkv(i_wr(64'h12),  o_cmd(1, 0, {64'h12, 64'h11})));
        tbl.push_back(mkv(i_wr(64'h13),  o_none()));
        tbl.push_back(mkv(i_wr(64'h14),  o_cmd(0, 0, {64'h14, 64'h13})));
        tbl.push_back(mkv(i_wr(64'h15),  o_none()));
        tbl.push_back(mkv(i_wr(64'h16),  o_cmd(0, 1, {64'h16, 64'h15})));
        tbl.push_back(mkv(i_wr(64'h0),   o_none()));
        tbl.push_back(mkv(i_wr(64'h5),   o_none()));
        tbl.push_back(mkv(i_wr(64'h105), o_none()));
        tbl.push_back(mkv(i_wr(64'h77),  o_none()));
        tbl.push_back(mkv(i_wr(64'h1),   o_none()));
        tbl.push_back(mkv(i_wr(64'h21),  o_none()));
        tbl.push_back(mkv(i_wr(64'h22),  o_cmd(1, 1, {64'h22, 64'h21})));
        tbl.push_back(mkv(i_rsp(1, 1, {64'h2222, 64'h1111}), o_none()));
        tbl.push_back(mkv(i_rd(),        o_rsp(64'h1111)));
        tbl.push_back(mkv(i_rd(),        o_rsp(64'h2222)));
        tbl.push_back(mkv(i_rd(),        o_rsp(64'h0)));
        tbl.push_back(mkv(i_wr(64'h1),   o_none()));
        tbl.push_back(mkv(i_rd(),        o_rsp(64'h0)));
        tbl.push_back(mkv(i_wr(64'h31),  o_none()));
        tbl.push_back(mkv(i_rd(),        o_rsp(64'h0)));
        tbl.push_back(mkv(i_wr(64'h32),  o_cmd(1, 1, {64'h32, 64'h31})));

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].i, got);
            cmp_out($sformatf("tbl%0d", n), got, tbl[n].o);
        end
        cmp("n3_end_state_idle", MST_W'(o_dbg_cmd_state), '0);

        // Fill, overflow drops, drop mode, sop recovery, full-before-pop.
        for (int k = 1; k <= DEPTH; k++) step(i_rsp(k == 1, k == DEPTH, beat(k)), got);
        step(i_rsp(0, 0, beat(9)), got);
`ifdef Q_PKT_BRIDGE_STATS_EN
        cmp("drop_cnt_full", MST_W'(o_stat_drop_cnt), MST_W'(1));
`endif
        step(i_rsp(0, 0, beat(10)), got);
`ifdef Q_PKT_BRIDGE_STATS_EN
        cmp("drop_cnt_mode", MST_W'(o_stat_drop_cnt), MST_W'(2));
`endif
        step(i_rd(), got);
        cmp("drop_rd0", MST_W'(got.sdat), MST_W'(1));
        step(i_rd(), got);
        cmp("drop_rd1", MST_W'(got.sdat), MST_W'(101));
        step(i_rsp(1, 0, beat(11)), got);
        step(i_rd(), got);
        cmp("drop_rd2", MST_W'(got.sdat), MST_W'(2));
        v = i_rd();
        v.mvld = 1'b1; v.msop = 1'b1; v.meop = 1'b1; v.mdat = beat(12);
        step(v, got);
        cmp("pop_push_full_rd", MST_W'(got.sdat), MST_W'(102));
        step(i_rsp(1, 1, beat(13)), got);
        drain = '{3, 4, 5, 6, 7, 8, 11, 13};
        foreach (drain[j]) begin
            step(i_rd(), got);
            cmp($sformatf("drain%0d_lo", j), MST_W'(got.sdat), MST_W'(drain[j]));
            step(i_rd(), got);
            cmp($sformatf("drain%0d_hi", j), MST_W'(got.sdat), MST_W'(drain[j] + 100));
        end
        step(i_rd(), got);
        cmp("drained_empty_vld", MST_W'(got.svld), MST_W'(1));
        cmp("drained_empty_dat", MST_W'(got.sdat), '0);

        // Reset in the middle of a packet with a beat buffered.
        step(i_rsp(1, 1, beat(50)), got);
        step(i_wr(64'h2), got);
        step(i_wr(64'h41), got);
        do_reset("mid_data_reset");
        step(i_rd(), got);
        cmp("post_reset_empty", MST_W'(got.sdat), '0);
        step(i_wr(64'h1), got);
        step(i_wr(64'h61), got);
        step(i_wr(64'h62), got);
        cmp_out("post_reset_pkt", got, o_cmd(1, 1, {64'h62, 64'h61}));

        // Randomized traffic: alternate push-heavy and read-heavy phases.
        for (int c = 0; c < 3000; c++) begin
            v = '0;
            v.cvld = 1'($urandom_range(0, 1));
            v.crnw = ($urandom_range(0, 2) == 0) || (c % 1000 >= 500 && $urandom_range(0, 1) == 1);
            v.cdat = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v.cdat[7:0] = 8'($urandom_range(0, 6));
            v.mvld = (c % 1000 < 500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
            v.msop = ($urandom_range(0, 3) == 0);
            v.meop = 1'($urandom_range(0, 1));
            v.mdat = {$urandom, $urandom, $urandom, $urandom};
            step(v, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
